// File: rtl/button_debouncer_bank.sv
// Multi-channel mechanical button debouncer with press, release and auto-repeat pulses.
module button_debouncer_bank #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 480000,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 1200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_raw,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] repeat_pulse
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    // Pin level that means "not pressed"; also the synchroniser reset value
    localparam logic INACTIVE  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic REPEAT_ON = (REPEAT_EN != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        logic             sync1;
        logic             sync2;
        logic             p;
        logic [1:0]       state;
        logic [1:0]       state_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;
        logic [REP_W-1:0] rcnt;
        logic [REP_W-1:0] rcnt_nx;
        logic             periodic;
        logic             periodic_nx;
        logic             level_q;
        logic             level_nx;
        logic             press_q;
        logic             press_nx;
        logic             release_q;
        logic             release_nx;
        logic             repeat_q;
        logic             repeat_nx;

        // Two-flop synchroniser for the asynchronous pin
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1 <= INACTIVE;
                sync2 <= INACTIVE;
            end else begin
                sync1 <= btn_raw[g];
                sync2 <= sync1;
            end
        end

        // Normalised pin: 1 = pressed regardless of polarity
        assign p = sync2 ^ INACTIVE;

        // State, counters and registered outputs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= S_IDLE;
                cnt       <= '0;
                rcnt      <= '0;
                periodic  <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_nx;
                cnt       <= cnt_nx;
                rcnt      <= rcnt_nx;
                periodic  <= periodic_nx;
                level_q   <= level_nx;
                press_q   <= press_nx;
                release_q <= release_nx;
                repeat_q  <= repeat_nx;
            end
        end

        // Next-state, counter and pulse decode
        always_comb begin
            state_nx    = state;
            cnt_nx      = cnt;
            rcnt_nx     = rcnt;
            periodic_nx = periodic;
            press_nx    = 1'b0;
            release_nx  = 1'b0;
            repeat_nx   = 1'b0;
            case (state)
                S_IDLE: begin
                    if (p) begin
                        state_nx = S_PRESS_WAIT;
                        cnt_nx   = '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!p) begin
                        state_nx = S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nx    = S_HELD;
                        press_nx    = 1'b1;
                        rcnt_nx     = '0;
                        periodic_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (!p) begin
                        state_nx = S_RELEASE_WAIT;
                        cnt_nx   = '0;
                    end else if (rcnt == (periodic ? PERIOD_LAST : DELAY_LAST)) begin
                        rcnt_nx     = '0;
                        periodic_nx = 1'b1;
                        repeat_nx   = REPEAT_ON;
                    end else begin
                        rcnt_nx = rcnt + REP_W'(1);
                    end
                end
                S_RELEASE_WAIT: begin
                    // repeat timer is frozen here and resumes on a bounce back to HELD
                    if (p) begin
                        state_nx = S_HELD;
                    end else if (cnt == CNT_LAST) begin
                        state_nx   = S_IDLE;
                        release_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
            level_nx = (state_nx == S_HELD) || (state_nx == S_RELEASE_WAIT);
        end

        assign btn_level[g]     = level_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
        assign repeat_pulse[g]  = repeat_q;
    end

endmodule

// File: tb/tb_button_debouncer_bank.sv
// Randomised and directed checks of button_debouncer_bank against a run-length model.
module tb_button_debouncer_bank;

    localparam int NCH = 4;
    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] btn_raw = '1;
    logic [NCH-1:0] lvl, prs, rel, rep;
    logic [NCH-1:0] lvl_n, prs_n, rel_n, rep_n;

    always #5 clk = ~clk;

    button_debouncer_bank #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(lvl),
        .press_pulse(prs), .release_pulse(rel), .repeat_pulse(rep)
    );

    button_debouncer_bank #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1), .REPEAT_EN(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_norep (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(lvl_n),
        .press_pulse(prs_n), .release_pulse(rel_n), .repeat_pulse(rep_n)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: the debounced level flips once the synced pin has disagreed with it for
    // DEB+1 consecutive samples; repeats count pressed samples while settled in HELD.
    logic [NCH-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel, m_rep;
    int             m_run   [NCH];
    int             m_tick  [NCH];
    bit             m_first [NCH];
    bit             mp;

    task automatic model_step();
        if (rst) begin
            m_s1 = '1; m_s2 = '1;
            m_lvl = '0; m_prs = '0; m_rel = '0; m_rep = '0;
            for (int i = 0; i < NCH; i++) begin
                m_run[i] = 0; m_tick[i] = 0; m_first[i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                mp = ~m_s2[i];
                m_prs[i] = 1'b0; m_rel[i] = 1'b0; m_rep[i] = 1'b0;
                if (mp != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB + 1) begin
                        m_lvl[i] = mp;
                        m_run[i] = 0;
                        if (mp) begin
                            m_prs[i] = 1'b1; m_tick[i] = 0; m_first[i] = 1'b1;
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    if (m_lvl[i] && m_run[i] == 0) begin
                        m_tick[i]++;
                        if (m_tick[i] == (m_first[i] ? RD : RP)) begin
                            m_rep[i] = 1'b1; m_tick[i] = 0; m_first[i] = 1'b0;
                        end
                    end
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Per-cycle comparison plus pulse bookkeeping for the directed tests
    int n_prs[NCH], n_rel[NCH], n_rep[NCH];
    int last_prs[NCH], last_rel[NCH];
    int rep_q[$];

    initial forever begin
        @(negedge clk);
        chk("level", 32'(lvl), 32'(m_lvl));
        chk("press", 32'(prs), 32'(m_prs));
        chk("release", 32'(rel), 32'(m_rel));
        chk("repeat", 32'(rep), 32'(m_rep));
        chk("norep_level", 32'(lvl_n), 32'(m_lvl));
        chk("norep_press", 32'(prs_n), 32'(m_prs));
        chk("norep_release", 32'(rel_n), 32'(m_rel));
        chk("norep_repeat", 32'(rep_n), 32'd0);
        for (int i = 0; i < NCH; i++) begin
            if (prs[i]) begin n_prs[i]++; last_prs[i] = cyc; end
            if (rel[i]) begin n_rel[i]++; last_rel[i] = cyc; end
            if (rep[i]) begin n_rep[i]++; if (i == 3) rep_q.push_back(cyc); end
        end
    end

    task automatic clear_counts();
        @(posedge clk); #1;
        for (int i = 0; i < NCH; i++) begin
            n_prs[i] = 0; n_rel[i] = 0; n_rep[i] = 0;
            last_prs[i] = -1000; last_rel[i] = -1000;
        end
        rep_q.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sample_edge(output int t);
        @(posedge clk); #1;
        t = cyc;
    endtask

    task automatic read_point();
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst_check(input string nm);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk({nm, "_level"}, 32'(lvl), 32'd0);
        chk({nm, "_pulses"}, 32'(prs | rel | rep), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int t0, t1;
    int dur[NCH];

    initial begin
        for (int i = 0; i < NCH; i++) begin
            n_prs[i] = 0; n_rel[i] = 0; n_rep[i] = 0;
            last_prs[i] = -1000; last_rel[i] = -1000;
        end
        #12;
        chk("reset_outputs", 32'({lvl, prs, rel, rep}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(5);

        // ch0 pressed 40 cycles, then released
        clear_counts();
        @(negedge clk); btn_raw[0] = 1'b0;
        sample_edge(t0);
        cycles(40);
        btn_raw[0] = 1'b1;
        sample_edge(t1);
        cycles(20);
        read_point();
        chk("t1_press_count", 32'(n_prs[0]), 32'd1);
        chk("t1_release_count", 32'(n_rel[0]), 32'd1);
        chk("t1_press_latency", 32'(last_prs[0] - t0 + 1), 32'd11);
        chk("t1_release_latency", 32'(last_rel[0] - t1 + 1), 32'd11);
        chk("t1_other_presses", 32'(n_prs[1] + n_prs[2] + n_prs[3]), 32'd0);

        // ch1 chattering every 3 cycles never qualifies
        clear_counts();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); btn_raw[1] = ~btn_raw[1];
            cycles(2);
        end
        @(negedge clk); btn_raw[1] = 1'b1;
        cycles(20);
        read_point();
        chk("t2_press_count", 32'(n_prs[1]), 32'd0);
        chk("t2_release_count", 32'(n_rel[1]), 32'd0);

        // ch2 short release bounce is absorbed
        clear_counts();
        @(negedge clk); btn_raw[2] = 1'b0;
        cycles(30); btn_raw[2] = 1'b1;
        cycles(4);  btn_raw[2] = 1'b0;
        cycles(30); btn_raw[2] = 1'b1;
        cycles(20);
        read_point();
        chk("t3_press_count", 32'(n_prs[2]), 32'd1);
        chk("t3_release_count", 32'(n_rel[2]), 32'd1);

        // ch3 held 60 cycles with auto-repeat
        clear_counts();
        @(negedge clk); btn_raw[3] = 1'b0;
        cycles(60); btn_raw[3] = 1'b1;
        cycles(20);
        read_point();
        chk("t4_press_count", 32'(n_prs[3]), 32'd1);
        chk("t4_release_count", 32'(n_rel[3]), 32'd1);
        chk("t4_repeat_count", 32'(rep_q.size()), 32'd7);
        if (rep_q.size() >= 2) begin
            chk("t4_first_repeat", 32'(rep_q[0] - last_prs[3]), 32'd20);
            chk("t4_second_repeat", 32'(rep_q[1] - rep_q[0]), 32'd5);
            chk("t4_repeat_before_release", 32'(rep_q[rep_q.size()-1] < last_rel[3]), 32'd1);
        end else begin
            chk("t4_repeat_list", 32'(rep_q.size()), 32'd2);
        end

        // ch0 and ch3 pressed together
        clear_counts();
        @(negedge clk); btn_raw[0] = 1'b0; btn_raw[3] = 1'b0;
        cycles(15); btn_raw[0] = 1'b1; btn_raw[3] = 1'b1;
        cycles(20);
        read_point();
        chk("t5_same_cycle", 32'(last_prs[0] - last_prs[3]), 32'd0);
        chk("t5_counts", 32'(n_prs[0] + n_prs[3]), 32'd2);

        // reset mid-debounce, then mid-held, with the pin kept low
        clear_counts();
        @(negedge clk); btn_raw[0] = 1'b0;
        cycles(5);
        pulse_rst_check("t6_rst_press_wait");
        sample_edge(t0);
        cycles(15);
        pulse_rst_check("t6_rst_held");
        sample_edge(t1);
        cycles(15);
        read_point();
        chk("t6_press_count", 32'(n_prs[0]), 32'd2);
        chk("t6_press_latency", 32'(last_prs[0] - t1 + 1), 32'd11);
        chk("t6_no_release", 32'(n_rel[0]), 32'd0);
        @(negedge clk); btn_raw[0] = 1'b1;
        cycles(20);

        // random press/glitch traffic on all channels, with one async reset
        for (int i = 0; i < NCH; i++) dur[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (dur[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    dur[i] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(10, 60))
                                                        : int'($urandom_range(1, 8));
                end else begin
                    dur[i]--;
                end
            end
            if (c == 1500) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        @(negedge clk); btn_raw = '1;
        cycles(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
